// File: rtl/sync_srl_fifo.sv
// Shift-register FIFO with a registered output stage and empty-queue bypass.
// Ports: clock, reset_n (async low), valid_i/ready_o/data_i in, valid_o/ready_i/data_o out, level_o.
module sync_srl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic          push, load, rd, bypass, st_push;
    logic [CW-1:0] cnt_m1;
    logic [AW-1:0] rd_idx;

    assign ready_o = (count_q != CW'(DEPTH));
    assign push    = valid_i && ready_o;
    assign load    = !valid_q || ready_i;
    assign rd      = load && (count_q != '0);
    // Empty storage: the incoming word skips the shift array entirely.
    assign bypass  = load && (count_q == '0) && push;
    assign st_push = push && !bypass;
    assign cnt_m1  = count_q - CW'(1);
    assign rd_idx  = cnt_m1[AW-1:0];

    always_comb begin
        count_d = count_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (st_push && !rd) begin
            count_d = count_q + CW'(1);
        end else if (rd && !st_push) begin
            count_d = cnt_m1;
        end
        if (load) begin
            if (rd) begin
                // Oldest entry is read before this edge's shift moves it.
                data_d  = mem_q[rd_idx];
                valid_d = 1'b1;
            end else if (bypass) begin
                data_d  = data_i;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (st_push) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                mem_q[k] <= mem_q[k-1];
            end
            mem_q[0] <= data_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign level_o = count_q + CW'(valid_q);
endmodule
